// File: rtl/os_link_seq.sv
// Link bring-up sequencer: IDLE -> SLOS1 -> SLOS2 -> TS1 -> TS2 -> DATA, with per-phase timeout to ERROR.
// Outputs registered (one cycle after the deciding edge); no backpressure, os_sent pulses are simply counted.
module os_link_seq #(
    parameter int SLOS_N = 2,
    parameter int TS1_N  = 16,
    parameter int TS2_N  = 8,
    parameter int RX_M   = 8,
    parameter int TMO    = 1023
) (
    input  logic       fsm_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       os_sent,
    input  logic       rx_lanes_on,
    input  logic [3:0] os_in_l0,
    input  logic [3:0] os_in_l1,
    output logic [3:0] d_sel,
    output logic       data_os,
    output logic       link_up,
    output logic       err,
    output logic [2:0] state
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SLOS1 = 3'd1,
        S_SLOS2 = 3'd2,
        S_TS1   = 3'd3,
        S_TS2   = 3'd4,
        S_DATA  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]      d_sel_q;
    logic            data_os_q, link_up_q, err_q;

    logic [3:0]      phase_code;
    logic [CW-1:0]   tx_target;
    logic            in_phase, in_ts, exit_ok, lane_bad;

    function automatic logic [3:0] code_of(input state_t s);
        case (s)
            S_SLOS1: return 4'h1;
            S_SLOS2: return 4'h2;
            S_TS1:   return 4'h3;
            S_TS2:   return 4'h4;
            S_DATA:  return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    always_comb begin
        phase_code = code_of(state_q);
        in_phase   = (state_q == S_SLOS1) || (state_q == S_SLOS2) ||
                     (state_q == S_TS1)   || (state_q == S_TS2);
        in_ts      = (state_q == S_TS1) || (state_q == S_TS2);
        case (state_q)
            S_SLOS1, S_SLOS2: tx_target = CW'(SLOS_N);
            S_TS1:            tx_target = CW'(TS1_N);
            S_TS2:            tx_target = CW'(TS2_N);
            default:          tx_target = '0;
        endcase
        // exits look only at registered counts, so the completing os_sent takes effect one cycle later
        exit_ok = in_phase && (tx_cnt_q == tx_target) &&
                  (!in_ts || (rx_cnt_q == CW'(RX_M)));

        tx_cnt_d = tx_cnt_q;
        if (in_phase && os_sent && (tx_cnt_q < tx_target))
            tx_cnt_d = tx_cnt_q + 1'b1;

        tmo_cnt_d = tmo_cnt_q;
        if (in_phase && (tmo_cnt_q < CW'(TMO)))
            tmo_cnt_d = tmo_cnt_q + 1'b1;

        lane_bad = ((os_in_l0 != 4'h0) && (os_in_l0 != phase_code)) ||
                   ((os_in_l1 != 4'h0) && (os_in_l1 != phase_code));
        rx_cnt_d = '0;
        if (in_ts && rx_lanes_on) begin
            if ((os_in_l0 == phase_code) && (os_in_l1 == phase_code)) begin
                if (rx_cnt_q < CW'(RX_M))
                    rx_cnt_d = rx_cnt_q + 1'b1;
                else
                    rx_cnt_d = rx_cnt_q;
            end else if (!lane_bad) begin
                rx_cnt_d = rx_cnt_q;
            end
        end

        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERROR: if (start) state_d = S_SLOS1;
            S_SLOS1: if (exit_ok) state_d = S_SLOS2;
                     else if (tmo_cnt_q == CW'(TMO)) state_d = S_ERROR;
            S_SLOS2: if (exit_ok) state_d = S_TS1;
                     else if (tmo_cnt_q == CW'(TMO)) state_d = S_ERROR;
            S_TS1:   if (exit_ok) state_d = S_TS2;
                     else if (tmo_cnt_q == CW'(TMO)) state_d = S_ERROR;
            S_TS2:   if (exit_ok) state_d = S_DATA;
                     else if (tmo_cnt_q == CW'(TMO)) state_d = S_ERROR;
            default: state_d = state_q;
        endcase
        if (abort)
            state_d = S_IDLE;

        if (state_d != state_q) begin
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            d_sel_q   <= 4'h0;
            data_os_q <= 1'b0;
            link_up_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            d_sel_q   <= code_of(state_d);
            data_os_q <= (state_d == S_SLOS1) || (state_d == S_SLOS2) ||
                         (state_d == S_TS1)   || (state_d == S_TS2);
            link_up_q <= (state_d == S_DATA);
            err_q     <= (state_d == S_ERROR);
        end
    end

    assign d_sel   = d_sel_q;
    assign data_os = data_os_q;
    assign link_up = link_up_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_os_link_seq.sv
// Directed bench for os_link_seq: cycle table plus hand-written multi-cycle sequences.
module tb_os_link_seq;

    logic       fsm_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, os_sent = 1'b0, rx_lanes_on = 1'b0;
    logic [3:0] os_in_l0 = 4'h0, os_in_l1 = 4'h0;
    logic [3:0] d_sel;
    logic       data_os, link_up, err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    os_link_seq dut (
        .fsm_clk(fsm_clk), .rst(rst), .start(start), .abort(abort),
        .os_sent(os_sent), .rx_lanes_on(rx_lanes_on),
        .os_in_l0(os_in_l0), .os_in_l1(os_in_l1),
        .d_sel(d_sel), .data_os(data_os), .link_up(link_up), .err(err), .state(state)
    );

    always #5 fsm_clk = ~fsm_clk;

    typedef struct {
        logic       s, a, o;
        logic [2:0] st;
        logic [3:0] ds;
        logic       dos, lu, er;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] pk(input logic [2:0] s, input logic [3:0] d,
                                       input logic o, input logic l, input logic e);
        return {22'b0, s, d, o, l, e};
    endfunction

    function automatic logic [31:0] outs();
        return {22'b0, state, d_sel, data_os, link_up, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic o, input logic ron,
                        input logic [3:0] x0, input logic [3:0] x1);
        start = s; abort = a; os_sent = o; rx_lanes_on = ron;
        os_in_l0 = x0; os_in_l1 = x1;
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 4'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        chk("reset_outputs", outs(), pk(0, 0, 0, 0, 0));
        rst = 1'b0;
        idle();
    endtask

    task automatic goto_ts1();
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle();
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle();
        chk("goto_ts1", outs(), pk(3, 3, 1, 0, 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pulses, n;
        logic [31:0] seq;
        logic [3:0]  last;

        //             s  a  o   st ds    dos lu er
        tbl[0]  = '{0, 0, 0, 3'd0, 4'h0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 3'd0, 4'h0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 3'd1, 4'h1, 1, 0, 0};
        tbl[3]  = '{1, 0, 0, 3'd1, 4'h1, 1, 0, 0};
        tbl[4]  = '{0, 0, 1, 3'd1, 4'h1, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 3'd1, 4'h1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 3'd2, 4'h2, 1, 0, 0};
        tbl[7]  = '{0, 0, 1, 3'd2, 4'h2, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 3'd0, 4'h0, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 3'd0, 4'h0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 3'd1, 4'h1, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 3'd1, 4'h1, 1, 0, 0};
        tbl[12] = '{0, 0, 1, 3'd1, 4'h1, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 3'd2, 4'h2, 1, 0, 0};
        tbl[14] = '{0, 0, 1, 3'd2, 4'h2, 1, 0, 0};
        tbl[15] = '{0, 0, 1, 3'd2, 4'h2, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 3'd3, 4'h3, 1, 0, 0};
        tbl[17] = '{0, 1, 0, 3'd0, 4'h0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].o, 0, 4'h0, 4'h0);
            chk($sformatf("table[%0d]", i), outs(),
                pk(tbl[i].st, tbl[i].ds, tbl[i].dos, tbl[i].lu, tbl[i].er));
        end

        // full bring-up: os_sent every 4 cycles, lanes echo the phase code
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        pulses = 0; seq = 32'h0; last = 4'h0;
        for (int c = 0; c < 500 && !link_up; c++) begin
            if (d_sel != last) begin
                seq = {seq[27:0], d_sel};
                last = d_sel;
            end
            if ((c % 4 == 0) && data_os) pulses++;
            step(0, 0, (c % 4 == 0), 1, d_sel, d_sel);
        end
        if (d_sel != last) seq = {seq[27:0], d_sel};
        chk("bringup_link_up", outs(), pk(5, 8, 0, 1, 0));
        chk("bringup_dsel_seq", seq, 32'h0001_2348);
        chk("bringup_os_count", 32'(pulses), 32'd28);
        step(0, 0, 1, 1, 8, 8);
        step(1, 0, 1, 0, 0, 0);
        chk("data_holds", outs(), pk(5, 8, 0, 1, 0));
        step(0, 1, 0, 0, 0, 0);
        chk("data_abort", outs(), pk(0, 0, 0, 0, 0));

        // mismatch on lane 1 at rx_cnt=7 restarts the receive count
        goto_ts1();
        repeat (16) step(0, 0, 1, 0, 4'h3, 4'h3);
        repeat (7) step(0, 0, 0, 1, 4'h3, 4'h3);
        step(0, 0, 0, 1, 4'h3, 4'h4);
        repeat (4) step(0, 0, 0, 1, 4'h3, 4'h3);
        step(0, 0, 0, 1, 4'h0, 4'h0);
        repeat (3) step(0, 0, 0, 1, 4'h3, 4'h3);
        chk("rx_restart_still_ts1", outs(), pk(3, 3, 1, 0, 0));
        step(0, 0, 0, 1, 4'h3, 4'h3);
        chk("rx_eighth_match_ts1", outs(), pk(3, 3, 1, 0, 0));
        step(0, 0, 0, 1, 4'h3, 4'h3);
        chk("rx_enter_ts2", outs(), pk(4, 4, 1, 0, 0));

        // TS1 with lanes off times out after TMO+1 cycles in the phase
        goto_ts1();
        n = 1;
        for (int i = 0; i < 2000 && state == 3'd3; i++) begin
            step(0, 0, (i < 16), 0, 0, 0);
            if (state == 3'd3) n++;
        end
        chk("tmo_cycles_in_ts1", 32'(n), 32'd1024);
        chk("tmo_error_outputs", outs(), pk(6, 0, 0, 0, 1));
        repeat (3) step(0, 0, 1, 1, 4'h3, 4'h3);
        chk("error_sticky", outs(), pk(6, 0, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0);
        chk("error_restart", outs(), pk(1, 1, 1, 0, 0));

        // final SLOS2 os_sent lands as tmo_cnt reaches TMO: exit wins
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle();
        for (int i = 0; i <= 1022; i++) step(0, 0, (i == 0 || i == 1022), 0, 0, 0);
        chk("tmo_race_pre", outs(), pk(2, 2, 1, 0, 0));
        idle();
        chk("tmo_race_exit_wins", outs(), pk(3, 3, 1, 0, 0));

        // one cycle later the os_sent is too late
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle();
        for (int i = 0; i <= 1022; i++) step(0, 0, (i == 0), 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("tmo_late_os_error", outs(), pk(6, 0, 0, 0, 1));

        // TS2: start ignored, abort returns to IDLE
        goto_ts1();
        repeat (16) step(0, 0, 1, 1, 4'h3, 4'h3);
        step(0, 0, 0, 1, 4'h3, 4'h3);
        chk("enter_ts2", outs(), pk(4, 4, 1, 0, 0));
        step(1, 0, 0, 1, 4'h4, 4'h4);
        chk("ts2_start_ignored", outs(), pk(4, 4, 1, 0, 0));
        step(0, 1, 1, 1, 4'h4, 4'h4);
        chk("ts2_abort", outs(), pk(0, 0, 0, 0, 0));

        // asynchronous reset mid-TS1
        goto_ts1();
        repeat (3) step(0, 0, 1, 1, 4'h3, 4'h3);
        #3 rst = 1'b1;
        #1 chk("async_rst_ts1", outs(), pk(0, 0, 0, 0, 0));
        #1 rst = 1'b0;
        repeat (5) step(0, 0, 1, 1, 4'h3, 4'h3);
        chk("no_move_after_rst", outs(), pk(0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
